rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit output channel among 8 requesters.
- Each requester presents a 4-bit word plus a request. The block picks a winner and drives the 8:1 select with the encoded winner index.
- The selected word is registered and offered downstream on a valid/ready handshake.
- It sits in front of the 8:1 mux tree: the arbiter owns the select lines and the mux tree provides the data path.

Parameters:
- DATA_W, 4, width of each requester word and of out_data.
- NREQ, 8, number of requesters; fixed power of two; the select width is log2(NREQ) = 3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- req  input  NREQ  request per requester; bit i belongs to requester i.
- din  input  NREQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot, one-cycle pulse: the word of requester i was captured this edge.
- sel  output  3  encoded index of the current or last winner; drives s2,s1,s0 of the 8:1 mux (s2 = MSB).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_data  output  DATA_W  registered winning word.
- out_src  output  3  index of the requester that supplied out_data.

Behaviour:
- Reset (rst_n=0 at an edge) forces: state=IDLE, out_valid=0, out_data=0, out_src=0, sel=0, gnt=0, ptr=0. This applies mid-transfer too; a held word is discarded.
- ptr is the priority pointer. The winner is the first i with req[i]=1, searching ptr, ptr+1, …, ptr+7 modulo 8.
- States: IDLE, BUSY.
- IDLE:
  - If |req, then at the next edge: out_data<=din[win], out_src<=win, sel<=win, gnt<=onehot(win), out_valid<=1, ptr<=win+1 (mod 8), state->BUSY.
  - If no request: remain in IDLE, gnt=0.
- BUSY:
  - out_valid=1; out_data and out_src hold stable until accepted; gnt=0 except in the reload case below.
  - out_ready=0: hold everything, no grant.
  - out_ready=1 with |req: back-to-back reload in the same edge, using the already-updated ptr. Capture the new winner as in IDLE, pulse gnt, stay in BUSY. Throughput is 1 word per cycle.
  - out_ready=1 without |req: out_valid<=0, state->IDLE; out_data and out_src keep their last values.
- Latency: request to out_valid is 1 cycle. gnt asserts in the same cycle out_valid first shows the word.
- Requester contract:
  - After seeing gnt[i], the requester drops req[i] or presents its next word in the following cycle.
  - Dropping req without a grant is legal and never produces a grant.
  - The arbiter never captures din[i] while req[i]=0.
- Fairness: a continuously requesting requester waits at most 7 captures between its own grants.
- Wrap-around: a winner at index 7 sets ptr=0.
- A single requester may win on consecutive captures when no other req is set.
- Boundary cases:
  - req=0 in BUSY with out_ready=1 gives no spurious gnt.
  - All 8 requesting gives the order ptr..ptr+7.
  - A req change in the same cycle as an out_ready acceptance uses the req value sampled at that edge.
- sel changes only on a capture, so the mux select is stable while out_valid holds.

Test Plan:
- Reset, then req=8'b0000_0100, din[2]=4'hA, out_ready=1 -> next cycle: gnt=8'b0000_0100, out_valid=1, out_data=4'hA, out_src=2, sel=3'd2. Then IDLE once req drops.
- All req=8'hFF held, din[i]=i, out_ready=1 continuously, from reset -> out_src sequence 0,1,2,…,7,0,1 on consecutive cycles; gnt one-hot each cycle; out_valid stays 1.
- out_ready=0 for 5 cycles after a capture of requester 5 (din=4'h3) while req=8'hFF -> out_data=4'h3 and out_src=5 stable, gnt=0 for all 5 cycles. Then out_ready=1 captures requester 6.
- Wrap-around: ptr=7 after winner 6; req=8'b1000_0001 -> winner 7, then winner 0. ptr returns to 1.
- Mid-transfer reset: out_valid=1 holding 4'hF, assert rst_n=0 for one edge -> out_valid=0, out_data=0, sel=0, gnt=0. After release with req=8'b0010_0000 -> requester 5 wins (ptr=0 restart).
- req[3] pulses for 1 cycle while BUSY with out_ready=0, then drops before acceptance -> no gnt[3] ever issued; out_valid falls after acceptance.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle and downstream valid/ready channel
// shared by the round-robin arbiter and its neighbours.
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int NREQ   = 8
);
  localparam int SEL_W = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] din;
  logic [NREQ-1:0]        gnt;
  logic [SEL_W-1:0]       sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_src;

  modport master (
    output req, din, out_ready,
    input  gnt, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  req, din, out_ready,
    output gnt, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux tree.
// Winner's word is registered and offered on valid/ready.
module rr_mux_arbiter #(
  parameter int DATA_W = 4,
  parameter int NREQ   = 8
) (
  input logic            clk,
  input logic            rst_n,
  rr_mux_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NREQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  src_q, src_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;

  logic [SEL_W-1:0]  win;
  logic [SEL_W-1:0]  idx;
  logic              any;
  logic              capture;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + SEL_W'(k);
      if (!any && bus.req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  // Capture when empty, or when the held word leaves this edge.
  assign capture = any && ((state_q == IDLE) || bus.out_ready);

  // Next-state: capture, drain to idle, or hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    src_d   = src_q;
    data_d  = data_q;
    valid_d = valid_q;
    gnt_d   = '0;
    if (capture) begin
      data_d  = bus.din[win*DATA_W +: DATA_W];
      src_d   = win;
      sel_d   = win;
      gnt_d   = NREQ'(1) << win;
      valid_d = 1'b1;
      ptr_d   = win + SEL_W'(1);
      state_d = BUSY;
    end else if (state_q == BUSY && bus.out_ready) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
endmodule
